// File: rtl/clk_en_divider_bank.sv
// Bank of NUM_CH independent clock-enable generators: each channel pulses once every ratio+1 cycles,
// with ratio updates deferred to period boundaries, drain-on-disable and a global realign strobe.
module clk_en_divider_bank #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned RESET_RATIO = 1,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 cfg_wr,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [DIV_WIDTH-1:0] cfg_ratio,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic                 sync_start,
    output logic [NUM_CH-1:0]    clk_en_out,
    output logic [NUM_CH-1:0]    ch_active,
    output logic [NUM_CH-1:0]    cfg_pending,
    output logic [NUM_CH-1:0]    cfg_ack
);

    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DRAIN} ch_state_t;

    ch_state_t            state      [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt        [NUM_CH];
    logic [DIV_WIDTH-1:0] ratio      [NUM_CH];
    logic [DIV_WIDTH-1:0] pend_ratio [NUM_CH];
    logic [NUM_CH-1:0]    pend;
    logic [NUM_CH-1:0]    ack;
    logic [NUM_CH-1:0]    wrap;

    // Pulse and wrap are the same registered decode, so the enable never sees an input path.
    always_comb begin
        wrap      = '0;
        ch_active = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wrap[i]      = (state[i] != ST_OFF) && (cnt[i] == ratio[i]);
            ch_active[i] = (state[i] != ST_OFF);
        end
    end

    assign clk_en_out  = wrap;
    assign cfg_pending = pend;
    assign cfg_ack     = ack;

    always_ff @(posedge clk_in) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                state[i]      <= ST_OFF;
                cnt[i]        <= '0;
                ratio[i]      <= DIV_WIDTH'(RESET_RATIO);
                pend_ratio[i] <= DIV_WIDTH'(RESET_RATIO);
                pend[i]       <= 1'b0;
                ack[i]        <= 1'b0;
            end else begin
                ack[i] <= 1'b0;
                // Apply only where cnt is (or is forced) to zero, so cnt can never exceed the new ratio.
                if (pend[i] && ((state[i] == ST_OFF) || wrap[i] || sync_start)) begin
                    ratio[i] <= pend_ratio[i];
                    pend[i]  <= 1'b0;
                    ack[i]   <= 1'b1;
                end
                // Out-of-range cfg_ch matches no channel; a same-edge write re-arms pend after the apply.
                if (cfg_wr && (32'(cfg_ch) == i)) begin
                    pend_ratio[i] <= cfg_ratio;
                    pend[i]       <= 1'b1;
                end
                case (state[i])
                    ST_OFF: begin
                        if (ch_enable[i]) begin
                            state[i] <= ST_RUN;
                            cnt[i]   <= '0;
                        end
                    end
                    default: begin
                        cnt[i] <= (wrap[i] || sync_start) ? '0 : cnt[i] + 1'b1;
                        if (ch_enable[i])
                            state[i] <= ST_RUN;
                        else if (wrap[i])
                            state[i] <= ST_OFF;
                        else
                            state[i] <= ST_DRAIN;
                    end
                endcase
            end
        end
    end

endmodule
